// File: rtl/spi_flash_reader.sv
// -----------------------------------------------------------------------------
// spi_flash_reader
//
// WISHBONE slave that streams bytes out of a SPI configuration flash. The host
// programs a 24-bit start address and a byte count, writes GO, and the block
// issues a READ command followed by the address, then clocks the requested
// number of data bytes into a receive FIFO that the host drains through the
// DATA register. SCK is held low whenever the FIFO is full at the start of a
// byte, so no byte is ever lost.
//
// Optional build macro: SPI_FAST_READ_EN
//   defined   : opcode 8'h0B, 8 dummy SCK cycles between address and data,
//               CTRL/STAT bit31 reads 1.
//   undefined : opcode READ_CMD, no dummy cycles, CTRL/STAT bit31 reads 0.
//
// Ports
//   clk_i, rst_n_i   system clock, asynchronous active-low reset
//   cyc_i, stb_i     WISHBONE cycle/strobe (ack_o = cyc_i & stb_i)
//   we_i, adr_i      write enable, byte address (adr_i[3:2] selects register)
//   dat_i, sel_i     write data, byte selects (ignored, full-word writes)
//   dat_o, ack_o     read data, acknowledge (zero wait states)
//   err_o, rty_o     tied low
//   CS_B, SCK, MOSI  SPI outputs (mode 0, MSB first)
//   MISO             SPI input
//
// Register map (adr_i[3:2])
//   0 CTRL/STAT  W: bit0 GO, bit1 ABORT, bit2 clear FIFO + sticky bits
//                R: bit0 BUSY, bit1 DONE, bit2 UFLOW, [15:8] FIFO count,
//                   bit31 fast-read build
//   1 ADDR       [23:0]
//   2 LENGTH     [15:0]
//   3 DATA       R: pop {not_empty, 23'b0, byte}; empty read returns 0, sets UFLOW
// -----------------------------------------------------------------------------
module spi_flash_reader #(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned FIFO_LOG2 = 4,
    parameter logic [7:0]  READ_CMD  = 8'h03
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [5:0]  adr_i,
    input  logic [31:0] dat_i,
    input  logic [3:0]  sel_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        rty_o,
    output logic        CS_B,
    output logic        SCK,
    output logic        MOSI,
    input  logic        MISO
);

    localparam int unsigned            LP_CW      = FIFO_LOG2 + 1;
    localparam logic [LP_CW-1:0]       LP_FULL    = LP_CW'(1 << FIFO_LOG2);
    localparam logic [LP_CW-1:0]       LP_CNT_ONE = LP_CW'(1);
    localparam logic [FIFO_LOG2-1:0]   LP_PTR_ONE = FIFO_LOG2'(1);
    localparam logic [7:0]             LP_RELOAD  = 8'(CLK_DIV - 1);

`ifdef SPI_FAST_READ_EN
    localparam logic [7:0] LP_OPCODE = 8'h0B;
    localparam logic       LP_FAST   = 1'b1;
`else
    localparam logic [7:0] LP_OPCODE = READ_CMD;
    localparam logic       LP_FAST   = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_CMD   = 3'd2,
        ST_ADDR  = 3'd3,
`ifdef SPI_FAST_READ_EN
        ST_DUMMY = 3'd4,
`endif
        ST_DATA  = 3'd5,
        ST_HOLD  = 3'd6
    } state_t;

    // FSM / shift engine
    state_t             r_state, w_state_nxt;
    logic [7:0]         r_div, w_div_nxt;
    logic               r_sck, w_sck_nxt;
    logic [4:0]         r_bits, w_bits_nxt;
    logic [31:0]        r_tx, w_tx_nxt;
    logic [7:0]         r_rx, w_rx_nxt;
    logic [15:0]        r_bytes, w_bytes_nxt;
    logic               r_abort_pend;
    logic               r_cs_b, w_cs_b_nxt;
    logic               r_mosi, w_mosi_nxt;
    logic               w_push;
    logic               w_fsm_done;
    logic               w_tick;
    logic               w_stall;

    // Host-visible registers
    logic [23:0]        r_addr;
    logic [15:0]        r_length;
    logic               r_done;
    logic               r_uflow;

    // Receive FIFO
    logic [7:0]         r_mem [0:(1 << FIFO_LOG2)-1];
    logic [FIFO_LOG2-1:0] r_wptr, r_rptr;
    logic [LP_CW-1:0]   r_count;

    // Bus decode
    logic               w_acc, w_wr, w_rd;
    logic               w_go, w_abort, w_clr;
    logic               w_data_rd, w_empty, w_full, w_pop;
    logic               w_done_set, w_busy;
    logic [31:0]        w_dat;
    logic               w_unused_bits;

    assign w_acc     = cyc_i & stb_i;
    assign w_wr      = w_acc & we_i;
    assign w_rd      = w_acc & ~we_i;
    assign w_go      = w_wr & (adr_i[3:2] == 2'd0) & dat_i[0];
    assign w_abort   = w_wr & (adr_i[3:2] == 2'd0) & dat_i[1];
    assign w_clr     = w_wr & (adr_i[3:2] == 2'd0) & dat_i[2];
    assign w_data_rd = w_rd & (adr_i[3:2] == 2'd3);
    assign w_empty   = (r_count == {LP_CW{1'b0}});
    assign w_full    = (r_count == LP_FULL);
    assign w_pop     = w_data_rd & ~w_empty;
    assign w_busy    = (r_state != ST_IDLE);
    assign w_tick    = (r_div == 8'd0);
    // A new data byte may not start its first SCK rise while the FIFO is full.
    assign w_stall   = (r_state == ST_DATA) & ~r_sck & (r_bits == 5'd7) & w_full;
    assign w_done_set = w_fsm_done | (w_go & (r_state == ST_IDLE) & (r_length == 16'd0));

    assign w_unused_bits = ^{sel_i, adr_i[5:4], adr_i[1:0], dat_i[31:24]};

    assign ack_o = w_acc;
    assign err_o = 1'b0;
    assign rty_o = 1'b0;
    assign dat_o = w_dat;
    assign CS_B  = r_cs_b;
    assign SCK   = r_sck;
    assign MOSI  = r_mosi;

    // Pin values follow the next state so CS_B/MOSI change together with it.
    assign w_cs_b_nxt = (w_state_nxt == ST_IDLE) | (w_state_nxt == ST_HOLD);
    assign w_mosi_nxt = ((w_state_nxt == ST_CMD) | (w_state_nxt == ST_ADDR)) ? w_tx_nxt[31] : 1'b0;

    // Read data multiplexer
    always_comb begin
        w_dat = 32'h0000_0000;
        case (adr_i[3:2])
            2'd0: w_dat = {LP_FAST, 15'h0000, 8'(r_count), 5'b00000, r_uflow, r_done, w_busy};
            2'd1: w_dat = {8'h00, r_addr};
            2'd2: w_dat = {16'h0000, r_length};
            2'd3: begin
                if (w_empty) begin
                    w_dat = 32'h0000_0000;
                end else begin
                    w_dat = {1'b1, 23'h000000, r_mem[r_rptr]};
                end
            end
            default: w_dat = 32'h0000_0000;
        endcase
    end

    // Next-state and shift-engine logic
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_sck_nxt   = r_sck;
        w_bits_nxt  = r_bits;
        w_tx_nxt    = r_tx;
        w_rx_nxt    = r_rx;
        w_bytes_nxt = r_bytes;
        w_push      = 1'b0;
        w_fsm_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_sck_nxt = 1'b0;
                w_div_nxt = LP_RELOAD;
                if (w_go && (r_length != 16'd0)) begin
                    w_state_nxt = ST_SETUP;
                    w_tx_nxt    = {LP_OPCODE, r_addr};
                    w_bytes_nxt = r_length;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (r_abort_pend) begin
                    w_state_nxt = ST_HOLD;
                    w_div_nxt   = LP_RELOAD;
                end else if (w_tick) begin
                    w_state_nxt = ST_CMD;
                    w_bits_nxt  = 5'd7;
                    w_div_nxt   = LP_RELOAD;
                end else begin
                    w_div_nxt = r_div - 8'd1;
                end
            end
`ifdef SPI_FAST_READ_EN
            ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: begin
`else
            ST_CMD, ST_ADDR, ST_DATA: begin
`endif
                if (!r_sck) begin
                    // Low half: the only place an abort or a full-FIFO stall can act.
                    if (r_abort_pend) begin
                        w_state_nxt = ST_HOLD;
                        w_div_nxt   = LP_RELOAD;
                    end else if (w_stall) begin
                        w_div_nxt = LP_RELOAD;
                    end else if (w_tick) begin
                        w_sck_nxt = 1'b1;
                        w_div_nxt = LP_RELOAD;
                        w_rx_nxt  = {r_rx[6:0], MISO};
                    end else begin
                        w_div_nxt = r_div - 8'd1;
                    end
                end else begin
                    if (w_tick) begin
                        w_sck_nxt = 1'b0;
                        w_div_nxt = LP_RELOAD;
                        w_tx_nxt  = {r_tx[30:0], 1'b0};
                        if (r_abort_pend) begin
                            // Falling edge is a low point: drop any partial byte.
                            w_state_nxt = ST_HOLD;
                        end else if (r_bits != 5'd0) begin
                            w_bits_nxt = r_bits - 5'd1;
                        end else begin
                            case (r_state)
                                ST_CMD: begin
                                    w_state_nxt = ST_ADDR;
                                    w_bits_nxt  = 5'd23;
                                end
                                ST_ADDR: begin
`ifdef SPI_FAST_READ_EN
                                    w_state_nxt = ST_DUMMY;
`else
                                    w_state_nxt = ST_DATA;
`endif
                                    w_bits_nxt  = 5'd7;
                                end
`ifdef SPI_FAST_READ_EN
                                ST_DUMMY: begin
                                    w_state_nxt = ST_DATA;
                                    w_bits_nxt  = 5'd7;
                                end
`endif
                                ST_DATA: begin
                                    w_push      = 1'b1;
                                    w_bytes_nxt = r_bytes - 16'd1;
                                    w_bits_nxt  = 5'd7;
                                    if (r_bytes == 16'd1) begin
                                        w_state_nxt = ST_HOLD;
                                    end else begin
                                        w_state_nxt = ST_DATA;
                                    end
                                end
                                default: w_state_nxt = ST_IDLE;
                            endcase
                        end
                    end else begin
                        w_div_nxt = r_div - 8'd1;
                    end
                end
            end
            ST_HOLD: begin
                w_sck_nxt = 1'b0;
                if (w_tick) begin
                    w_state_nxt = ST_IDLE;
                    w_fsm_done  = 1'b1;
                end else begin
                    w_div_nxt = r_div - 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_sck_nxt   = 1'b0;
                w_div_nxt   = LP_RELOAD;
            end
        endcase
    end

    // FSM state, shift engine and SPI pin registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
            r_div   <= LP_RELOAD;
            r_sck   <= 1'b0;
            r_bits  <= 5'd0;
            r_tx    <= 32'h0000_0000;
            r_rx    <= 8'h00;
            r_bytes <= 16'h0000;
            r_cs_b  <= 1'b1;
            r_mosi  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_sck   <= w_sck_nxt;
            r_bits  <= w_bits_nxt;
            r_tx    <= w_tx_nxt;
            r_rx    <= w_rx_nxt;
            r_bytes <= w_bytes_nxt;
            r_cs_b  <= w_cs_b_nxt;
            r_mosi  <= w_mosi_nxt;
        end
    end

    // Abort request, held until the engine reaches HOLD or IDLE
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_abort_pend <= 1'b0;
        end else if (w_abort && (r_state != ST_IDLE) && (r_state != ST_HOLD)) begin
            r_abort_pend <= 1'b1;
        end else if ((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_HOLD)) begin
            r_abort_pend <= 1'b0;
        end
    end

    // Host registers and sticky status bits
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_addr   <= 24'h000000;
            r_length <= 16'h0000;
            r_done   <= 1'b0;
            r_uflow  <= 1'b0;
        end else begin
            if (w_wr && (adr_i[3:2] == 2'd1)) begin
                r_addr <= dat_i[23:0];
            end
            if (w_wr && (adr_i[3:2] == 2'd2)) begin
                r_length <= dat_i[15:0];
            end
            // A completion that coincides with a clear still gets reported.
            r_done  <= w_done_set | (r_done & ~w_clr);
            r_uflow <= (w_data_rd & w_empty) | (r_uflow & ~w_clr);
        end
    end

    // FIFO pointers and occupancy; a clear empties it but keeps a same-cycle push
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wptr  <= {FIFO_LOG2{1'b0}};
            r_rptr  <= {FIFO_LOG2{1'b0}};
            r_count <= {LP_CW{1'b0}};
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + LP_PTR_ONE;
            end
            if (w_clr) begin
                r_rptr  <= r_wptr;
                r_count <= {{FIFO_LOG2{1'b0}}, w_push};
            end else begin
                if (w_pop) begin
                    r_rptr <= r_rptr + LP_PTR_ONE;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + LP_CNT_ONE;
                    2'b01:   r_count <= r_count - LP_CNT_ONE;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // FIFO storage
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= r_rx;
        end
    end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Self-checking bench for spi_flash_reader: a behavioural SPI flash answers the
// READ command from a byte array, and expected FIFO contents and SCK counts are
// derived from the transfer address/length.
module tb_spi_flash_reader;

    localparam int CLK_DIV   = 2;
    localparam int FIFO_LOG2 = 4;
`ifdef SPI_FAST_READ_EN
    localparam logic [7:0]  OPC   = 8'h0B;
    localparam int          HDR   = 40;
    localparam logic [31:0] FASTB = 32'h8000_0000;
`else
    localparam logic [7:0]  OPC   = 8'h03;
    localparam int          HDR   = 32;
    localparam logic [31:0] FASTB = 32'h0000_0000;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [5:0]  adr = 6'd0;
    logic [31:0] wdat = 32'd0;
    logic [3:0]  sel = 4'hF;
    logic [31:0] rdat;
    logic        ack, err, rty, cs_b, sck, mosi;
    logic        miso = 1'b0;

    always #5 clk = ~clk;

    spi_flash_reader #(.CLK_DIV(CLK_DIV), .FIFO_LOG2(FIFO_LOG2), .READ_CMD(8'h03)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .cyc_i(cyc), .stb_i(stb), .we_i(we),
        .adr_i(adr), .dat_i(wdat), .sel_i(sel), .dat_o(rdat), .ack_o(ack),
        .err_o(err), .rty_o(rty), .CS_B(cs_b), .SCK(sck), .MOSI(mosi), .MISO(miso)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  flash_mem [0:4095];
    int          bit_n = 0, sck_rises = 0, cs_falls = 0;
    logic [31:0] hdr_cap = 32'd0;
    int          mk;
    logic [7:0]  mb;
    logic [7:0]  exp_q [$];
    logic        last_ack;

    // Flash model: header shifted in on SCK rise, data driven on SCK fall.
    always @(negedge cs_b) begin
        bit_n = 0;
        cs_falls++;
    end
    always @(posedge sck) begin
        if (!cs_b) begin
            if (bit_n < 32) hdr_cap = {hdr_cap[30:0], mosi};
            bit_n++;
            sck_rises++;
        end
    end
    always @(negedge sck) begin
        if (!cs_b && bit_n >= HDR) begin
            mk   = bit_n - HDR;
            mb   = flash_mem[hdr_cap[11:0] + 12'(mk / 8)];
            miso = mb[7 - (mk % 8)];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wb_write(input logic [1:0] r, input logic [31:0] d);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = {2'b00, r, 2'b00}; wdat = d;
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input logic [1:0] r, output logic [31:0] d);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = {2'b00, r, 2'b00};
        #2;
        d = rdat;
        last_ack = ack;
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        logic [31:0] d;
        d = 32'h1;
        for (int i = 0; i < budget && d[0]; i++) wb_read(2'd0, d);
        check_val("idle_timeout", {31'd0, d[0]}, 32'd0);
    endtask

    // Pop expecting the model's next byte, or an empty read once exhausted.
    task automatic pop_check(input string tag);
        logic [31:0] d;
        logic [7:0]  b;
        wb_read(2'd3, d);
        if (exp_q.size() == 0) begin
            check_val(tag, d, 32'h0);
        end else begin
            b = exp_q.pop_front();
            check_val(tag, d, {1'b1, 23'd0, b});
        end
    endtask

    // Pop while a transfer may still be filling the FIFO.
    task automatic pop_live(input string tag);
        logic [31:0] d;
        logic [7:0]  b;
        wb_read(2'd3, d);
        if (d[31]) begin
            if (exp_q.size() == 0) begin
                check_val({tag, "_extra"}, d, 32'h0);
            end else begin
                b = exp_q.pop_front();
                check_val(tag, d, {1'b1, 23'd0, b});
            end
        end else begin
            check_val({tag, "_empty"}, d, 32'h0);
        end
    endtask

    task automatic load_exp(input logic [23:0] a, input int len);
        exp_q.delete();
        for (int i = 0; i < len; i++) exp_q.push_back(flash_mem[a[11:0] + 12'(i)]);
    endtask

    initial begin
        logic [31:0] d;
        logic [23:0] a;
        int          len;
        int          lat;

        for (int i = 0; i < 4096; i++) flash_mem[i] = 8'($urandom);
        flash_mem[12'h345] = 8'hA5;
        flash_mem[12'h346] = 8'h3C;
        flash_mem[12'h347] = 8'hFF;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_csb",  {31'd0, cs_b}, 32'd1);
        check_val("rst_sck",  {31'd0, sck},  32'd0);
        check_val("rst_mosi", {31'd0, mosi}, 32'd0);
        check_val("rst_ack",  {31'd0, ack},  32'd0);
        check_val("err_rty",  {30'd0, err, rty}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        wb_read(2'd0, d); check_val("rst_stat", d, FASTB);
        check_val("ack_read", {31'd0, last_ack}, 32'd1);
        wb_read(2'd1, d); check_val("rst_addr", d, 32'd0);
        wb_read(2'd2, d); check_val("rst_len",  d, 32'd0);

        // Directed 3-byte read at 0x012345
        wb_write(2'd1, 32'hFF01_2345);
        wb_write(2'd2, 32'd3);
        wb_read(2'd1, d); check_val("addr_rb", d, 32'h0001_2345);
        sck_rises = 0;
        wb_write(2'd0, 32'd1);
        wait_idle(400);
        check_val("hdr_a",   hdr_cap, {OPC, 24'h012345});
        check_val("rises_a", 32'(sck_rises), 32'(HDR + 24));
        wb_read(2'd0, d); check_val("stat_a", d, FASTB | 32'h0000_0302);
        load_exp(24'h012345, 3);
        pop_check("pop_a0"); pop_check("pop_a1"); pop_check("pop_a2");
        pop_check("pop_a_uf");
        wb_read(2'd0, d); check_val("stat_uf", d, FASTB | 32'h0000_0006);

        // GO with LENGTH=0
        wb_write(2'd0, 32'd4);
        wb_write(2'd2, 32'd0);
        cs_falls = 0;
        wb_write(2'd0, 32'd1);
        wb_read(2'd0, d); check_val("len0_stat", d, FASTB | 32'h0000_0002);
        check_val("len0_cs", 32'(cs_falls), 32'd0);

        // Second GO while busy is ignored
        wb_write(2'd0, 32'd4);
        a = 24'($urandom);
        wb_write(2'd1, {8'd0, a});
        wb_write(2'd2, 32'd2);
        wb_write(2'd0, 32'd1);
        wb_write(2'd2, 32'd5);
        wb_write(2'd0, 32'd1);
        wait_idle(400);
        wb_read(2'd0, d); check_val("go2_stat", d, FASTB | 32'h0000_0202);
        wb_read(2'd2, d); check_val("go2_len",  d, 32'd5);
        load_exp(a, 2);
        pop_check("go2_p0"); pop_check("go2_p1");

        // Flow control: 20 bytes into a 16-deep FIFO
        wb_write(2'd0, 32'd4);
        a = 24'($urandom);
        wb_write(2'd1, {8'd0, a});
        wb_write(2'd2, 32'd20);
        load_exp(a, 20);
        sck_rises = 0;
        wb_write(2'd0, 32'd1);
        d = 32'd0;
        for (int i = 0; i < 2000 && d[15:8] != 8'd16; i++) wb_read(2'd0, d);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check_val("fc_sck",   {31'd0, sck},  32'd0);
        check_val("fc_csb",   {31'd0, cs_b}, 32'd0);
        check_val("fc_rises", 32'(sck_rises), 32'(HDR + 128));
        wb_read(2'd0, d); check_val("fc_stat", d, FASTB | 32'h0000_1001);
        for (int i = 0; i < 4; i++) pop_check("fc_pop");
        wait_idle(2000);
        wb_read(2'd0, d); check_val("fc_stat2", d, FASTB | 32'h0000_1002);
        check_val("fc_rises2", 32'(sck_rises), 32'(HDR + 160));
        for (int i = 0; i < 16; i++) pop_check("fc_drain");

        // ABORT during the address phase
        wb_write(2'd0, 32'd4);
        wb_write(2'd2, 32'd5);
        wb_write(2'd0, 32'd1);
        for (int i = 0; i < 500 && bit_n < 12; i++) @(posedge clk);
        check_val("ab_reach", {31'd0, (bit_n >= 12)}, 32'd1);
        wb_write(2'd0, 32'd2);
        for (int i = 0; i < 20 && sck; i++) @(negedge clk);
        lat = 0;
        while (cs_b == 1'b0 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_val("ab_lat", {31'd0, (lat <= CLK_DIV + 1)}, 32'd1);
        wait_idle(200);
        wb_read(2'd0, d); check_val("ab_stat", d, FASTB | 32'h0000_0002);

        // Randomized transfers with host pops racing the incoming bytes
        for (int t = 0; t < 4; t++) begin
            wb_write(2'd0, 32'd4);
            a   = 24'($urandom);
            len = $urandom_range(1, 12);
            load_exp(a, len);
            sck_rises = 0;
            wb_write(2'd1, {8'd0, a});
            wb_write(2'd2, 32'(len));
            wb_write(2'd0, 32'd1);
            d = 32'h1;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    pop_live("rnd_pop");
                end else begin
                    wb_read(2'd0, d);
                    if (!d[0]) break;
                end
            end
            check_val("rnd_idle",  {31'd0, d[0]}, 32'd0);
            check_val("rnd_hdr",   hdr_cap, {OPC, a});
            check_val("rnd_rises", 32'(sck_rises), 32'(HDR + 8 * len));
            wb_read(2'd0, d);
            check_val("rnd_cnt", {24'd0, d[15:8]}, 32'(exp_q.size()));
            while (exp_q.size() != 0) pop_check("rnd_drain");
            pop_check("rnd_uf");
        end

        // Reset in the middle of the data phase
        wb_write(2'd0, 32'd4);
        wb_write(2'd2, 32'd8);
        wb_write(2'd0, 32'd1);
        for (int i = 0; i < 1000 && bit_n < HDR + 10; i++) @(posedge clk);
        check_val("mr_reach", {31'd0, (bit_n >= HDR + 10)}, 32'd1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_val("mr_csb",  {31'd0, cs_b}, 32'd1);
        check_val("mr_sck",  {31'd0, sck},  32'd0);
        check_val("mr_mosi", {31'd0, mosi}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        wb_read(2'd0, d); check_val("mr_stat", d, FASTB);
        wb_read(2'd1, d); check_val("mr_addr", d, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
